// File: rtl/mem_bus_master.sv
// mem_bus_master: single-request load/store initiator driving a synchronous RAM port.
// Latency: accept-to-resp_valid is 2 cycles (store), 2+READ_WAIT (load), 1 (out-of-range).
// Backpressure: req_ready only in IDLE; requests offered while busy are ignored, never queued.
//
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   req_valid/req_ready     - request handshake; req_we, req_addr (MAR), req_wdata (MDR)
//   resp_valid/resp_err     - one-cycle completion pulse, error = address out of range
//   resp_rdata              - last successful load data, held between loads
//   busy                    - inverse of req_ready
//   mem_address/mem_read/mem_write/mem_data_out/mem_data_in - RAM port
module mem_bus_master #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int READ_WAIT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        r_state;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [2:0]        r_cnt;

    logic w_accept;
    logic w_out_of_range;
    logic w_issue;
    logic w_wait;

    assign w_accept       = req_valid && (r_state == S_IDLE);
    assign w_out_of_range = |req_addr[31:ADDR_W];
    assign w_issue        = (r_state == S_ISSUE);
    assign w_wait         = (r_state == S_WAIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_wdata <= req_wdata;
                        if (w_out_of_range) begin
                            // No RAM access: the address register keeps the last
                            // driven value so mem_address does not glitch.
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end else begin
                            r_addr  <= req_addr[ADDR_W-1:0];
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= 3'(READ_WAIT - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_rdata <= mem_data_in;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = !req_ready;
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;
    assign resp_rdata = r_rdata;

    // RAM strobes are gated by reset so a store whose ISSUE cycle
    // coincides with a reset edge never commits.
    assign mem_address  = r_addr;
    assign mem_write    = !reset && w_issue && r_we;
    assign mem_read     = !reset && ((w_issue && !r_we) || w_wait);
    assign mem_data_out = (!reset && w_issue && r_we) ? r_wdata : '0;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: scoreboard bench for mem_bus_master with two instances (READ_WAIT 1 and 3).
// Latency: expected response cycle is pushed at issue and compared by the monitor on resp_valid.
// Backpressure: requests are offered only when req_ready, or held with junk while busy.
module tb_mem_bus_master;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT0: READ_WAIT = 1
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, busy, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_data_out, mem_data_in;
    logic [8:0]  mem_address;

    // DUT1: READ_WAIT = 3
    logic        req_valid1 = 1'b0, req_we1 = 1'b0;
    logic [31:0] req_addr1 = '0, req_wdata1 = '0;
    logic        req_ready1, resp_valid1, resp_err1, busy1, mem_read1, mem_write1;
    logic [31:0] resp_rdata1, mem_data_out1, mem_data_in1;
    logic [8:0]  mem_address1;

    mem_bus_master #(.ADDR_W(9), .DATA_W(32), .READ_WAIT(1)) u_dut0 (
        .clock(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .busy(busy), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
    );

    mem_bus_master #(.ADDR_W(9), .DATA_W(32), .READ_WAIT(3)) u_dut1 (
        .clock(clk), .reset(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_err(resp_err1), .resp_rdata(resp_rdata1),
        .busy(busy1), .mem_address(mem_address1), .mem_read(mem_read1),
        .mem_write(mem_write1), .mem_data_out(mem_data_out1), .mem_data_in(mem_data_in1)
    );

    // Synchronous RAMs: registered read address, one-cycle read latency.
    logic [31:0] ram0 [0:511];
    logic [31:0] ram1 [0:511];
    logic [8:0]  rd0 = '0, rd1 = '0;

    always @(posedge clk) begin
        if (mem_write) ram0[mem_address] <= mem_data_out;
        if (mem_read) rd0 <= mem_address;
        if (mem_write1) ram1[mem_address1] <= mem_data_out1;
        if (mem_read1) rd1 <= mem_address1;
    end
    assign mem_data_in  = ram0[rd0];
    assign mem_data_in1 = ram1[rd1];

    exp_t q0[$];
    exp_t q1[$];
    wr_t  wq[$];
    int   rd_cnt0 = 0, rd_cnt1 = 0, wr_cnt0 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_evt(input string nm);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor: compares every response and RAM write against the scoreboard queues.
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (resp_valid) begin
            if (q0.size() == 0) fail_evt("dut0_unexpected_resp");
            else begin
                e = q0.pop_front();
                chk("dut0_resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("dut0_resp_rdata", resp_rdata, e.rd);
                chk("dut0_resp_cycle", cyc, e.cyc);
            end
        end
        if (mem_write) begin
            wr_cnt0++;
            if (wq.size() == 0) fail_evt("dut0_unexpected_write");
            else begin
                w = wq.pop_front();
                chk("dut0_write_addr", {23'd0, mem_address}, {23'd0, w.a});
                chk("dut0_write_data", mem_data_out, w.d);
            end
        end
        if (mem_read) rd_cnt0++;
        if (resp_valid1) begin
            if (q1.size() == 0) fail_evt("dut1_unexpected_resp");
            else begin
                e = q1.pop_front();
                chk("dut1_resp_err", {31'd0, resp_err1}, {31'd0, e.err});
                chk("dut1_resp_rdata", resp_rdata1, e.rd);
                chk("dut1_resp_cycle", cyc, e.cyc);
            end
        end
        if (mem_write1) fail_evt("dut1_unexpected_write");
        if (mem_read1) rd_cnt1++;
    end

    // Offer one request to DUT0. While waiting for req_ready, either drop valid or
    // (hold=1) keep valid high with junk in-range stores that must be ignored.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic exp_err, input logic [31:0] exp_rd, input int lat,
                          input bit hold);
        int  n = 0;
        bit  done = 0;
        wr_t w;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
                q0.push_back('{exp_err, exp_rd, cyc + lat});
                if (we && !exp_err) begin
                    w.a = addr[8:0];
                    w.d = data;
                    wq.push_back(w);
                end
                done = 1;
            end else begin
                if (hold) begin
                    req_valid = 1'b1; req_we = 1'b1;
                    req_addr = 32'h40 + n; req_wdata = 32'hBAD0_0000 + n;
                end else begin
                    req_valid = 1'b0;
                end
                n++;
                if (n > 50) begin
                    fail_evt("dut0_ready_timeout");
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while (!(q0.size() == 0 && q1.size() == 0 && req_ready && req_ready1)) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                fail_evt("idle_timeout");
                q0.delete();
                q1.delete();
                break;
            end
        end
    endtask

    initial begin
        int r0, w0;
        for (int i = 0; i < 512; i++) begin
            ram0[i] = 32'hC0DE_0000 | i;
            ram1[i] = 32'h7777_0000 | i;
        end
        ram0[9'h95] = 32'h0000_0022;
        ram0[9'd90] = 32'h0000_0012;
        ram1[9'h44] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_address", {23'd0, mem_address}, 32'd0);
        chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_data_out", mem_data_out, 32'd0);

        // Store then load at 0x87.
        w0 = wr_cnt0;
        do_req(1'b1, 32'h87, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0);
        wait_idle();
        chk("store_write_count", wr_cnt0 - w0, 32'd1);
        r0 = rd_cnt0;
        do_req(1'b0, 32'h87, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0);
        wait_idle();
        chk("load_read_cycles", rd_cnt0 - r0, 32'd2);
        chk("idle_holds_address", {23'd0, mem_address}, 32'h87);

        // Preloaded loads; the second is offered with valid held high while busy.
        do_req(1'b0, 32'h95, 32'h0, 1'b0, 32'h22, 3, 0);
        do_req(1'b0, 32'd90, 32'h0, 1'b0, 32'h12, 3, 1);
        wait_idle();

        // Out-of-range store and load: error response, no RAM access.
        w0 = wr_cnt0; r0 = rd_cnt0;
        do_req(1'b1, 32'h200, 32'h1, 1'b1, 32'h12, 1, 0);
        do_req(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h12, 1, 0);
        wait_idle();
        chk("oor_no_write", wr_cnt0 - w0, 32'd0);
        chk("oor_no_read", rd_cnt0 - r0, 32'd0);
        chk("oor_ram0_unchanged", ram0[0], 32'hC0DE_0000);
        chk("oor_address_held", {23'd0, mem_address}, 32'd90);

        // Back-to-back stores with junk requests held on the bus while busy.
        w0 = wr_cnt0;
        do_req(1'b1, 32'h30, 32'h1111_0030, 1'b0, 32'h12, 2, 1);
        do_req(1'b1, 32'h31, 32'h1111_0031, 1'b0, 32'h12, 2, 1);
        do_req(1'b1, 32'h32, 32'h1111_0032, 1'b0, 32'h12, 2, 1);
        wait_idle();
        chk("b2b_write_count", wr_cnt0 - w0, 32'd3);
        chk("b2b_ram_0x31", ram0[9'h31], 32'h1111_0031);
        chk("b2b_junk_untouched", ram0[9'h40], 32'hC0DE_0040);

        // Reset during a store's ISSUE cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hAAAA5555;
        @(posedge clk);
        #1 rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_issue_no_write", {31'd0, mem_write}, 32'd0);
        chk("rst_issue_data_out", mem_data_out, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_resp_rdata", resp_rdata, 32'd0);
        chk("post_rst_mem_address", {23'd0, mem_address}, 32'd0);
        chk("post_rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_ram_0x10_kept", ram0[9'h10], 32'hC0DE_0010);

        // RAM contents survive the reset.
        do_req(1'b0, 32'h87, 32'h0, 1'b0, 32'hDEADBEEF, 3, 0);
        wait_idle();

        // READ_WAIT = 3 instance.
        @(negedge clk);
        req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 32'h44;
        q1.push_back('{1'b0, 32'h1234_5678, cyc + 5});
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        wait_idle();
        chk("rw3_read_cycles", rd_cnt1, 32'd4);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog_timeout (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Memory-side initiator for the Mini-SRC datapath: accepts single load/store requests from the control unit (MAR/MDR values) over a valid/ready handshake and drives the synchronous 512×32 RAM port (registered read address, one-cycle read latency, write on rising edge). Returns read data with a one-cycle response pulse. Sits between the CPU control sequencer/MDR and the RAM instance.

## Interface
Parameters:
- ADDR_W, 9, RAM address width; valid word range 0 … 2^ADDR_W−1
- DATA_W, 32, data width
- READ_WAIT, 1, cycles from the read issue edge to the data-capture edge; legal range 1–4

Ports:
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  master idle; the request is accepted on an edge where valid && ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  MAR value
- req_wdata  in  DATA_W  MDR value for stores
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; address out of range
- resp_rdata  out  DATA_W  last load data; held until the next successful load
- busy  out  1  equals !req_ready
- mem_address  out  ADDR_W  to RAM address
- mem_read  out  1  to RAM read
- mem_write  out  1  to RAM write
- mem_data_out  out  DATA_W  to RAM write data
- mem_data_in  in  DATA_W  from RAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On acceptance, latch we, addr[ADDR_W−1:0] and wdata.
  - If req_addr[31:ADDR_W] != 0, go to RESP with err flag set; no RAM access occurs.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_address = latched address.
  - Store: mem_write=1, mem_data_out = latched wdata; RAM writes on the exiting edge; next state RESP.
  - Load: mem_read=1; next state WAIT with wait counter = READ_WAIT−1.
- WAIT (loads only):
  - mem_read=1 and mem_address held.
  - If counter==0: capture mem_data_in into resp_rdata on this edge and go to RESP.
  - Else decrement the counter and stay.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_err = err flag.
  - Next state IDLE; err flag cleared.
- mem_address holds its last driven value in IDLE and RESP.
- mem_read and mem_write are 0 outside ISSUE/WAIT.
- mem_read, mem_write and mem_data_out are registered-state decodes gated with !reset, so no RAM write commits on a reset cycle.
- req_valid outside IDLE is ignored; no queueing.
- resp_err responses leave resp_rdata unchanged.

## Timing
- Reset: state IDLE; req_ready=1, busy=0; resp_valid=0, resp_err=0; resp_rdata=0; mem_address=0, mem_read=0, mem_write=0, mem_data_out=0; latched registers and counter cleared.
- Accept edge = E0.
- Store: mem_write high during the cycle after E0; resp_valid high during the cycle after E1; req_ready high again after E2. Throughput is 1 store per 3 cycles.
- Load: mem_read high from the cycle after E0 for 1+READ_WAIT cycles; data captured at edge E(READ_WAIT+1); resp_valid high during the following cycle.
  - Accept-to-resp_valid latency is 2+READ_WAIT cycles.
  - Throughput is 1 load per 3+READ_WAIT cycles.
- Out-of-range request: resp_valid=1, resp_err=1 in the cycle after E0; mem_read and mem_write stay 0.
- Reset mid-operation:
  - Any state returns to IDLE at the reset edge and the access is abandoned.
  - A store whose ISSUE cycle coincides with reset does not write.
  - No resp_valid is produced for an abandoned access.
- resp_rdata changes only at the load capture edge or at reset.

## Test plan
- Store then load, READ_WAIT=1:
  - Store addr 0x87, data 0xDEADBEEF → mem_write=1 for 1 cycle with mem_address=0x87; resp_valid 2 cycles after accept.
  - Load 0x87 → resp_rdata=0xDEADBEEF with resp_valid 3 cycles after accept; resp_err=0.
- Preloaded RAM word 0x95=0x00000022: load 0x95 → resp_rdata=0x22. A following load of 90 (word=0x12) issued with req_valid held high continuously is accepted only when req_ready returns → resp_rdata=0x12.
- Out of range: store addr 0x200, data 0x1 → resp_err=1 one cycle after accept; mem_write never asserted; RAM[0] unchanged.
- Reset during a store's ISSUE cycle (addr 0x10, data 0xAAAA5555) → RAM[0x10] keeps its old value; all outputs return to reset values; no resp_valid.
- READ_WAIT=3: load of word 0x12345678 → mem_read high 4 cycles, resp_valid 5 cycles after accept, data correct.
- Back-to-back: req_valid held high with changing addresses while busy → exactly one access per accept; the ignored requests cause no RAM activity.
